// File: rtl/pic_eep_pkg.sv
// Shared types and defaults for the PIC16F84 data-EEPROM responder.
// State encoding, default geometry/timing, and the counter width helper.
package pic_eep_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_PROG = 2'd2,
    DONE    = 2'd3
  } eep_state_e;

  localparam int DEF_ADDR_W       = 6;
  localparam int DEF_READ_LAT     = 2;
  localparam int DEF_WRITE_CYCLES = 16;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pic_eeprom_ctrl_if.sv
// Core <-> data-EEPROM request/acknowledge bus; master is the CPU core.
// Requests are levels, acks are single-cycle pulses.
interface pic_eeprom_ctrl_if;
  logic [7:0] eepadr;
  logic [7:0] eepdtout;
  logic       readeepreq;
  logic       writeeepreq;
  logic [7:0] eepdtin;
  logic       readeepack;
  logic       writeeepack;
  logic       existeeprom;
  logic       eep_busy;

  modport master (
    output eepadr, eepdtout, readeepreq, writeeepreq,
    input  eepdtin, readeepack, writeeepack, existeeprom, eep_busy
  );

  modport slave (
    input  eepadr, eepdtout, readeepreq, writeeepreq,
    output eepdtin, readeepack, writeeepack, existeeprom, eep_busy
  );
endinterface

// File: rtl/pic_eeprom_ctrl_eep_array.sv
// Byte-wide 2**ADDR_W storage: synchronous write, registered read, 1-cycle read latency.
// No reset and no backpressure; contents survive controller reset.
module eep_array
  import pic_eep_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clkin,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_dat
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clkin) begin
    if (we) begin
      mem[wr_addr] <= wr_dat;
    end
    rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/pic_eeprom_ctrl.sv
// Data-EEPROM responder: read ack READ_LAT cycles, write ack WRITE_CYCLES cycles after acceptance.
// One operation at a time; requests are ignored while busy and in the DONE cycle.
module pic_eeprom_ctrl
  import pic_eep_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_LAT     = DEF_READ_LAT,
  parameter int WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic              clkin,
  input  logic              ponrst_n,
  pic_eeprom_ctrl_if.slave  eep
);

  localparam int CNT_W = cnt_width(READ_LAT, WRITE_CYCLES);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

  eep_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        dtin_q;
  logic              rd_ack_q;
  logic              wr_ack_q;
  logic              busy_q;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_rd_addr;
  logic [7:0]        arr_rd_dat;
  logic              unused_adr_hi;

  // Upper address bits alias onto the array.
  assign unused_adr_hi = ^eep.eepadr[7:ADDR_W];

  // In IDLE the array is addressed straight from the bus so a READ_LAT of 1
  // still finds valid registered read data on the ack edge.
  assign arr_rd_addr = (state == IDLE) ? eep.eepadr[ADDR_W-1:0] : addr_q;
  assign arr_we      = (state == WR_PROG) && (cnt == '0);

  eep_array #(.ADDR_W(ADDR_W)) u_array (
    .clkin   (clkin),
    .we      (arr_we),
    .wr_addr (addr_q),
    .wr_dat  (data_q),
    .rd_addr (arr_rd_addr),
    .rd_dat  (arr_rd_dat)
  );

  always_ff @(posedge clkin or negedge ponrst_n) begin
    if (!ponrst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      dtin_q   <= '0;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (eep.writeeepreq) begin
            addr_q <= eep.eepadr[ADDR_W-1:0];
            data_q <= eep.eepdtout;
            cnt    <= WR_LOAD;
            busy_q <= 1'b1;
            state  <= WR_PROG;
          end else if (eep.readeepreq) begin
            addr_q <= eep.eepadr[ADDR_W-1:0];
            cnt    <= RD_LOAD;
            busy_q <= 1'b1;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            dtin_q   <= arr_rd_dat;
            rd_ack_q <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_PROG: begin
          if (cnt == '0) begin
            wr_ack_q <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign eep.eepdtin     = dtin_q;
  assign eep.readeepack  = rd_ack_q;
  assign eep.writeeepack = wr_ack_q;
  assign eep.existeeprom = 1'b1;
  assign eep.eep_busy    = busy_q;

endmodule
